// File: rtl/fir_mc_engine_pkg.sv
// Shared types and defaults for the multi-channel FIR compute engine.
package fir_mc_engine_pkg;

  localparam int N_CH_DEFAULT    = 4;
  localparam int SHIFT_W_DEFAULT = 6;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    WAIT_X = 2'd1,
    MAC    = 2'd2,
    EMIT   = 2'd3
  } fir_mc_state_e;

  typedef struct packed {
    logic taps_loaded;
    logic busy;
    logic err;
  } fir_mc_flags_t;

  // Index width that never collapses to zero bits
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/fir_mc_engine_delay_line.sv
// Per-channel sample history: N_CH independent shift registers of NB_TAPS
// entries. Only the addressed channel shifts; entry 0 holds the newest sample.
module fir_mc_engine_delay_line
  import fir_mc_engine_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NB_TAPS    = 50,
  parameter int N_CH       = N_CH_DEFAULT,
  parameter int CH_W       = clog2_min1(N_CH),
  parameter int IDX_W      = clog2_min1(NB_TAPS)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic                         shift_en_i,
  input  logic [CH_W-1:0]              wr_ch_i,
  input  logic signed [DATA_WIDTH-1:0] wr_data_i,
  input  logic [CH_W-1:0]              rd_ch_i,
  input  logic [IDX_W-1:0]             rd_k_i,
  output logic signed [DATA_WIDTH-1:0] rd_data_o
);

  localparam int CI_W = clog2_min1(N_CH);

  logic signed [DATA_WIDTH-1:0] dl_q [N_CH][NB_TAPS];
  logic [CI_W-1:0] wr_idx;
  logic [CI_W-1:0] rd_idx;

  // Channel tags are range-checked upstream; narrow them to the array index
  assign wr_idx = CI_W'(wr_ch_i);
  assign rd_idx = CI_W'(rd_ch_i);

  // Shift the selected channel's history by one, inserting the new sample
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      for (int c = 0; c < N_CH; c++) begin
        for (int t = 0; t < NB_TAPS; t++) begin
          dl_q[c][t] <= '0;
        end
      end
    end else if (shift_en_i) begin
      dl_q[wr_idx][0] <= wr_data_i;
      for (int t = 1; t < NB_TAPS; t++) begin
        dl_q[wr_idx][t] <= dl_q[wr_idx][t-1];
      end
    end
  end

  assign rd_data_o = dl_q[rd_idx][rd_k_i];

endmodule

// File: rtl/fir_mc_engine.sv
// Time-multiplexed multi-channel FIR engine: one serial MAC, one shared
// coefficient bank, a private delay line per channel.
// Optional build macro FIR_MC_SATURATE_EN: saturate the rounded result to
// DATA_WIDTH; without it the result wraps (low DATA_WIDTH bits kept).
module fir_mc_engine
  import fir_mc_engine_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NB_TAPS    = 50,
  parameter int N_CH       = N_CH_DEFAULT,
  parameter int CH_W       = clog2_min1(N_CH),
  parameter int TAP_W      = $clog2(NB_TAPS + 1),
  parameter int SHIFT_W    = SHIFT_W_DEFAULT
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic [TAP_W-1:0]             nb_taps_i,
  input  logic [SHIFT_W-1:0]           shift_i,
  input  logic                         h_valid_i,
  output logic                         h_ready_o,
  input  logic signed [DATA_WIDTH-1:0] h_data_i,
  input  logic                         x_valid_i,
  output logic                         x_ready_o,
  input  logic signed [DATA_WIDTH-1:0] x_data_i,
  input  logic [CH_W-1:0]              x_ch_i,
  output logic                         y_valid_o,
  input  logic                         y_ready_i,
  output logic signed [DATA_WIDTH-1:0] y_data_o,
  output logic [CH_W-1:0]              y_ch_o,
  output logic                         taps_loaded_o,
  output logic                         busy_o,
  output logic                         err_o
);

  localparam int IDX_W   = clog2_min1(NB_TAPS);
  localparam int GUARD_W = clog2_min1(NB_TAPS);
  localparam int PROD_W  = 2 * DATA_WIDTH;
  localparam int ACC_W   = PROD_W + GUARD_W;

  fir_mc_state_e state_q;
  fir_mc_flags_t flags_q;

  logic [IDX_W-1:0]             k_q;
  logic [TAP_W-1:0]             ntaps_q;
  logic [TAP_W-1:0]             ntaps_eff;
  logic [CH_W-1:0]              ch_q;
  logic [CH_W-1:0]              y_ch_q;
  logic signed [DATA_WIDTH-1:0] coef_q [NB_TAPS];
  logic signed [DATA_WIDTH-1:0] coef_k;
  logic signed [DATA_WIDTH-1:0] dl_k;
  logic signed [DATA_WIDTH-1:0] y_data_q;
  logic signed [PROD_W-1:0]     prod;
  logic signed [ACC_W-1:0]      acc_q;
  logic signed [ACC_W-1:0]      acc_next;
  logic                         y_valid_q;
  logic                         h_ready_q;
  logic                         x_ready_q;
  logic                         h_fire;
  logic                         x_fire;
  logic                         y_fire;
  logic                         ch_ok;
  logic                         last_tap;
  logic                         shift_en;

  // (acc + 2^(s-1)) >>> s is computed as (acc >>> s) + bit s-1 of acc, which
  // is exact and cannot overflow for any shift amount.
  function automatic logic signed [ACC_W:0] round_shift(
    input logic signed [ACC_W-1:0] a,
    input logic [SHIFT_W-1:0]      s
  );
    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] rnd;
    logic [SHIFT_W-1:0]    sm1;
    ext = $signed({a[ACC_W-1], a});
    rnd = '0;
    sm1 = s - SHIFT_W'(1);
    if (s != '0) begin
      rnd[0] = (int'(sm1) >= ACC_W) ? ext[ACC_W] : ext[sm1];
    end
    return (ext >>> s) + rnd;
  endfunction

  // Narrow the rounded accumulator to the output width
  function automatic logic signed [DATA_WIDTH-1:0] reduce_out(
    input logic signed [ACC_W:0] v
  );
`ifdef FIR_MC_SATURATE_EN
    logic signed [ACC_W:0] sat_max;
    logic signed [ACC_W:0] sat_min;
    sat_max = $signed({{(ACC_W + 2 - DATA_WIDTH){1'b0}}, {(DATA_WIDTH - 1){1'b1}}});
    sat_min = ~sat_max;
    if (v > sat_max) return sat_max[DATA_WIDTH-1:0];
    if (v < sat_min) return sat_min[DATA_WIDTH-1:0];
    return v[DATA_WIDTH-1:0];
`else
    logic unused_hi;
    unused_hi = ^v[ACC_W:DATA_WIDTH];
    return v[DATA_WIDTH-1:0];
`endif
  endfunction

  assign ntaps_eff = (nb_taps_i == '0 || nb_taps_i > TAP_W'(NB_TAPS)) ?
                     TAP_W'(NB_TAPS) : nb_taps_i;

  assign h_fire   = h_valid_i & h_ready_q;
  assign x_fire   = x_valid_i & x_ready_q;
  assign y_fire   = y_valid_q & y_ready_i;
  assign ch_ok    = ({1'b0, x_ch_i} < (CH_W + 1)'(N_CH));
  assign last_tap = (TAP_W'(k_q) == ntaps_q - TAP_W'(1));
  assign shift_en = rst_ni & ~clear_i & (state_q == WAIT_X) & x_fire & ch_ok;

  fir_mc_engine_delay_line #(
    .DATA_WIDTH (DATA_WIDTH),
    .NB_TAPS    (NB_TAPS),
    .N_CH       (N_CH),
    .CH_W       (CH_W),
    .IDX_W      (IDX_W)
  ) u_delay_line (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (clear_i),
    .shift_en_i (shift_en),
    .wr_ch_i    (x_ch_i),
    .wr_data_i  (x_data_i),
    .rd_ch_i    (ch_q),
    .rd_k_i     (k_q),
    .rd_data_o  (dl_k)
  );

  // MAC datapath: one signed product per cycle folded into the accumulator
  always_comb begin
    coef_k   = coef_q[k_q];
    prod     = coef_k * dl_k;
    acc_next = acc_q + $signed({{GUARD_W{prod[PROD_W-1]}}, prod});
  end

  // Control FSM with registered handshakes, coefficient bank and accumulator
  always_ff @(posedge clk_i) begin
    flags_q.err <= 1'b0;
    if (!rst_ni || clear_i) begin
      state_q   <= LOAD;
      flags_q   <= '0;
      k_q       <= '0;
      ntaps_q   <= ntaps_eff;
      ch_q      <= '0;
      acc_q     <= '0;
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
      y_ch_q    <= '0;
      h_ready_q <= 1'b1;
      x_ready_q <= 1'b0;
      for (int i = 0; i < NB_TAPS; i++) begin
        coef_q[i] <= '0;
      end
    end else begin
      case (state_q)
        LOAD: begin
          if (h_fire) begin
            coef_q[k_q] <= h_data_i;
            if (last_tap) begin
              k_q                 <= '0;
              h_ready_q           <= 1'b0;
              x_ready_q           <= 1'b1;
              flags_q.taps_loaded <= 1'b1;
              state_q             <= WAIT_X;
            end else begin
              k_q <= k_q + IDX_W'(1);
            end
          end
        end
        WAIT_X: begin
          if (x_fire) begin
            if (ch_ok) begin
              ch_q         <= x_ch_i;
              acc_q        <= '0;
              k_q          <= '0;
              x_ready_q    <= 1'b0;
              flags_q.busy <= 1'b1;
              state_q      <= MAC;
            end else begin
              flags_q.err <= 1'b1;
            end
          end
        end
        MAC: begin
          acc_q <= acc_next;
          if (last_tap) begin
            y_data_q  <= reduce_out(round_shift(acc_next, shift_i));
            y_ch_q    <= ch_q;
            y_valid_q <= 1'b1;
            k_q       <= '0;
            state_q   <= EMIT;
          end else begin
            k_q <= k_q + IDX_W'(1);
          end
        end
        EMIT: begin
          if (y_fire) begin
            y_valid_q    <= 1'b0;
            x_ready_q    <= 1'b1;
            flags_q.busy <= 1'b0;
            state_q      <= WAIT_X;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign h_ready_o     = h_ready_q;
  assign x_ready_o     = x_ready_q;
  assign y_valid_o     = y_valid_q;
  assign y_data_o      = y_data_q;
  assign y_ch_o        = y_ch_q;
  assign taps_loaded_o = flags_q.taps_loaded;
  assign busy_o        = flags_q.busy;
  assign err_o         = flags_q.err;

endmodule

// File: tb/tb_fir_mc_engine.sv
// Directed bench for fir_mc_engine: DATA_WIDTH=16, NB_TAPS=8, N_CH=2 with a
// 2-bit channel tag so that an out-of-range channel can be presented.
module tb_fir_mc_engine;

  localparam int DW = 16;
  localparam int NT = 8;
  localparam int NC = 2;
  localparam int CW = 2;
  localparam int TW = 4;
  localparam int SW = 6;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 clear = 1'b0;
  logic [TW-1:0]        nb_taps = 4'd4;
  logic [SW-1:0]        shift = '0;
  logic                 h_valid = 1'b0;
  logic                 h_ready;
  logic signed [DW-1:0] h_data = '0;
  logic                 x_valid = 1'b0;
  logic                 x_ready;
  logic signed [DW-1:0] x_data = '0;
  logic [CW-1:0]        x_ch = '0;
  logic                 y_valid;
  logic                 y_ready = 1'b0;
  logic signed [DW-1:0] y_data;
  logic [CW-1:0]        y_ch;
  logic                 taps_loaded;
  logic                 busy;
  logic                 err;

  logic signed [DW-1:0] tap_vec [NT];
  int n_tests = 0;
  int n_fail  = 0;

  fir_mc_engine #(
    .DATA_WIDTH (DW),
    .NB_TAPS    (NT),
    .N_CH       (NC),
    .CH_W       (CW),
    .TAP_W      (TW),
    .SHIFT_W    (SW)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .clear_i       (clear),
    .nb_taps_i     (nb_taps),
    .shift_i       (shift),
    .h_valid_i     (h_valid),
    .h_ready_o     (h_ready),
    .h_data_i      (h_data),
    .x_valid_i     (x_valid),
    .x_ready_o     (x_ready),
    .x_data_i      (x_data),
    .x_ch_i        (x_ch),
    .y_valid_o     (y_valid),
    .y_ready_i     (y_ready),
    .y_data_o      (y_data),
    .y_ch_o        (y_ch),
    .taps_loaded_o (taps_loaded),
    .busy_o        (busy),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input logic [TW-1:0] nt);
    @(negedge clk);
    nb_taps = nt;
    rst_n   = 1'b0;
    h_valid = 1'b0;
    x_valid = 1'b0;
    y_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic load_taps(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!h_ready) check("h_ready_in_load", {31'b0, h_ready}, 32'd1);
      h_valid = 1'b1;
      h_data  = tap_vec[i];
      @(posedge clk);
      #1;
    end
    h_valid = 1'b0;
    check("taps_loaded", {31'b0, taps_loaded}, 32'd1);
    check("h_ready_after_load", {31'b0, h_ready}, 32'd0);
    check("x_ready_after_load", {31'b0, x_ready}, 32'd1);
  endtask

  // Returns #1 after the clock edge at which the sample was accepted
  task automatic send_x(input logic signed [DW-1:0] d, input logic [CW-1:0] c);
    int guard;
    guard = 0;
    @(negedge clk);
    x_valid = 1'b1;
    x_data  = d;
    x_ch    = c;
    while (!x_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!x_ready) check("x_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    x_valid = 1'b0;
  endtask

  task automatic wait_y(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!y_valid && lat < 200);
    if (!y_valid) check("y_timeout", 32'd0, 32'd1);
  endtask

  task automatic take_y(input logic signed [DW-1:0] exp_d, input logic [CW-1:0] exp_c,
                        input string tag);
    @(negedge clk);
    check({tag, "_data"}, y_data, exp_d);
    check({tag, "_ch"}, {30'b0, y_ch}, {30'b0, exp_c});
    y_ready = 1'b1;
    @(posedge clk);
    #1;
    y_ready = 1'b0;
    check({tag, "_vld_drop"}, {31'b0, y_valid}, 32'd0);
  endtask

  task automatic run_one(input logic signed [DW-1:0] d, input logic [CW-1:0] c,
                         input logic signed [DW-1:0] exp_d, input int exp_lat,
                         input string tag);
    int lat;
    send_x(d, c);
    wait_y(lat);
    check({tag, "_lat"}, lat, exp_lat);
    take_y(exp_d, c, tag);
  endtask

  initial begin
    int  lat;
    logic bad;
    logic xr_bad;
    logic seen;
    logic signed [DW-1:0] d0;
    logic [CW-1:0] c0;
    logic signed [DW-1:0] sat_exp;

    // Reset state and impulse response
    do_reset(4'd4);
    check("rst_h_ready", {31'b0, h_ready}, 32'd1);
    check("rst_x_ready", {31'b0, x_ready}, 32'd0);
    check("rst_y_valid", {31'b0, y_valid}, 32'd0);
    check("rst_taps_loaded", {31'b0, taps_loaded}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    for (int i = 0; i < NT; i++) tap_vec[i] = DW'(i + 1);
    load_taps(4);
    run_one(16'sd1, 2'd0, 16'sd1, 4, "imp0");
    run_one(16'sd0, 2'd0, 16'sd2, 4, "imp1");
    run_one(16'sd0, 2'd0, 16'sd3, 4, "imp2");
    run_one(16'sd0, 2'd0, 16'sd4, 4, "imp3");
    run_one(16'sd0, 2'd0, 16'sd0, 4, "imp4");

    // Channel isolation with interleaved samples
    run_one(16'sd1,  2'd0, 16'sd1,   4, "iso_c0a");
    run_one(16'sd10, 2'd1, 16'sd10,  4, "iso_c1a");
    run_one(16'sd0,  2'd0, 16'sd2,   4, "iso_c0b");
    run_one(16'sd10, 2'd1, 16'sd30,  4, "iso_c1b");
    run_one(16'sd0,  2'd0, 16'sd3,   4, "iso_c0c");
    run_one(16'sd10, 2'd1, 16'sd60,  4, "iso_c1c");
    run_one(16'sd0,  2'd0, 16'sd4,   4, "iso_c0d");
    run_one(16'sd10, 2'd1, 16'sd100, 4, "iso_c1d");
    run_one(16'sd10, 2'd1, 16'sd100, 4, "iso_c1e");

    // Invalid channel: consumed, one-cycle err, no result, no history change
    send_x(16'sd7, 2'd3);
    check("inv_err_hi", {31'b0, err}, 32'd1);
    check("inv_busy", {31'b0, busy}, 32'd0);
    check("inv_x_ready", {31'b0, x_ready}, 32'd1);
    @(posedge clk);
    #1;
    check("inv_err_lo", {31'b0, err}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (y_valid) seen = 1'b1;
    end
    check("inv_no_y", {31'b0, seen}, 32'd0);
    run_one(16'sd5, 2'd0, 16'sd5,  4, "inv_next_c0");
    run_one(16'sd0, 2'd1, 16'sd90, 4, "inv_next_c1");

    // Full-scale product: saturate or wrap at shift 0 (nb_taps=0 selects 8)
`ifdef FIR_MC_SATURATE_EN
    sat_exp = 16'sh7FFF;
`else
    sat_exp = 16'sh0001;
`endif
    do_reset(4'd0);
    shift = 6'd0;
    for (int i = 0; i < NT; i++) tap_vec[i] = 16'sh7FFF;
    load_taps(8);
    run_one(16'sh7FFF, 2'd0, sat_exp, 8, "sat_s0");

    // Same data with shift 15 after a soft clear
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("clr_h_ready", {31'b0, h_ready}, 32'd1);
    check("clr_taps_loaded", {31'b0, taps_loaded}, 32'd0);
    shift = 6'd15;
    load_taps(8);
    run_one(16'sh7FFF, 2'd0, 16'sh7FFE, 8, "sat_s15");

    // Backpressure: result held stable for 10 cycles, no new sample accepted
    send_x(16'sd0, 2'd0);
    wait_y(lat);
    check("bp_lat", lat, 8);
    d0 = y_data;
    c0 = y_ch;
    bad = 1'b0;
    xr_bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (!y_valid || y_data !== d0 || y_ch !== c0) bad = 1'b1;
      if (x_ready) xr_bad = 1'b1;
    end
    check("bp_stable", {31'b0, bad}, 32'd0);
    check("bp_x_ready_low", {31'b0, xr_bad}, 32'd0);
    take_y(16'sh7FFE, 2'd0, "bp");
    shift = 6'd0;

    // Clear in the middle of a MAC run aborts it
    do_reset(4'd4);
    for (int i = 0; i < NT; i++) tap_vec[i] = DW'(i + 1);
    load_taps(4);
    send_x(16'sd1, 2'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("mid_busy", {31'b0, busy}, 32'd1);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("mid_h_ready", {31'b0, h_ready}, 32'd1);
    check("mid_taps_loaded", {31'b0, taps_loaded}, 32'd0);
    check("mid_busy_clr", {31'b0, busy}, 32'd0);
    check("mid_x_ready", {31'b0, x_ready}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (y_valid) seen = 1'b1;
    end
    check("mid_no_y", {31'b0, seen}, 32'd0);
    load_taps(4);
    run_one(16'sd0, 2'd0, 16'sd0, 4, "mid_hist_cleared");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_mc_engine.md
Name: fir_mc_engine

Overview:
- Next-generation FIR compute engine for the FIR HWPE: time-multiplexed, multi-channel, runtime-configurable tap count.
- One shared serial multiplier-accumulator (MAC) and one shared coefficient bank; each channel has its own delay line.
- Sits between the streamer and the output store: consumes a serial coefficient stream and a channel-tagged sample stream, and emits channel-tagged, rounded results.
- Replaces the fixed single-channel parallel datapath/tap-buffer pair.

Parameters:
- DATA_WIDTH, 16, signed sample/coefficient/result width.
- NB_TAPS, 50, maximum taps (coefficient bank and delay-line depth).
- N_CH, 4, number of independent channels.
- CH_W, $clog2(N_CH) (min 1), channel tag width.
- TAP_W, $clog2(NB_TAPS+1), tap-count width.
- SHIFT_W, 6, output right-shift field width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- clear_i  in  1  synchronous soft clear, same effect as reset
- nb_taps_i  in  TAP_W  active tap count, latched on entry to LOAD; 0 means NB_TAPS
- shift_i  in  SHIFT_W  output arithmetic right shift, static while busy_o=1
- h_valid_i / h_ready_o  in/out  1  coefficient handshake
- h_data_i  in  DATA_WIDTH  coefficient, h[0] first
- x_valid_i / x_ready_o  in/out  1  sample handshake
- x_data_i  in  DATA_WIDTH  sample
- x_ch_i  in  CH_W  sample channel
- y_valid_o / y_ready_i  out/in  1  result handshake
- y_data_o  out  DATA_WIDTH  result
- y_ch_o  out  CH_W  result channel
- taps_loaded_o  out  1  coefficient bank complete
- busy_o  out  1  state is MAC or EMIT
- err_o  out  1  one-cycle pulse on an invalid-channel sample

Behaviour:
- Reset / clear:
  - State goes to LOAD.
  - Coefficients, delay lines, accumulator and counters go to 0.
  - All outputs go to 0, except h_ready_o=1 from the first cycle after reset/clear.
  - clear_i in any state, including mid-MAC or EMIT, aborts the operation; no y is emitted.
- Handshake rules (valid/ready):
  - A transfer occurs when valid and ready are both high on a clock edge.
  - Once y_valid_o rises, it stays high with y_data_o and y_ch_o stable until accepted.
- LOAD:
  - h_ready_o=1.
  - Each h transfer writes coef[k] and increments k.
  - The transfer at k=ntaps-1 sets taps_loaded_o=1 and moves to WAIT_X.
- WAIT_X:
  - x_ready_o=1.
  - On a transfer with x_ch_i<N_CH:
    - shift the sample into dl[x_ch_i][0]; older entries shift up; entry NB_TAPS-1 is dropped;
    - latch the channel, set acc=0 and k=0, go to MAC.
  - On a transfer with x_ch_i>=N_CH: the sample is consumed and discarded, err_o pulses, state stays WAIT_X.
- MAC:
  - Each cycle: acc += coef[k]*dl[ch][k], then k++.
  - After the cycle with k=ntaps-1, go to EMIT.
  - Latency is exactly ntaps cycles from x acceptance to y_valid_o.
- EMIT:
  - y_valid_o=1.
  - On a y transfer, go to WAIT_X; x_ready_o is low until then.
- Arithmetic:
  - Products are signed 2*DATA_WIDTH.
  - acc is signed 2*DATA_WIDTH+$clog2(NB_TAPS).
  - For shift s>0, the result is (acc + 2^(s-1)) >>> s (round half up); for s=0 it is acc.
  - The result is then reduced to DATA_WIDTH according to the optional feature below.
- Channels are independent: a channel's history changes only on its own samples.
- Reloading coefficients requires clear_i.

Optional Feature:
- Macro: FIR_MC_SATURATE_EN.
- Defined: the result saturates to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Undefined: the result is truncated to its low DATA_WIDTH bits (two's-complement wrap).

Decomposition:
- fir_package gains:
  - fir_mc_state_e {LOAD, WAIT_X, MAC, EMIT};
  - fir_mc_flags_t {taps_loaded, busy, err};
  - default constants for N_CH and SHIFT_W.
- One sub-module: fir_mc_delay_line. It holds N_CH x NB_TAPS registers with a write-enable shift for the selected channel and a combinational read port (ch, k).

Test Plan (DATA_WIDTH=16, NB_TAPS=8, N_CH=2, shift=0 unless stated):
1. Impulse response: taps {1,2,3,4}, nb_taps=4; ch0 samples 1,0,0,0,0 -> y=1,2,3,4,0 on ch0, each exactly 4 cycles after x acceptance.
2. Channel isolation: same taps; ch0 gets 1,0,0,0 and ch1 gets 10,10,10,10,10, interleaved -> ch0 y=1,2,3,4; ch1 y=10,30,60,100,100.
3. Saturation: 8 taps of 0x7FFF, x=0x7FFF:
   - with shift=0, first y=0x7FFF when SATURATE_EN is defined, 0x0001 when it is not;
   - with shift=15, first y=0x7FFE.
4. Backpressure: y_ready_i low for 10 cycles in EMIT -> y_valid_o, y_data_o and y_ch_o stable; x_ready_o=0 throughout; the accepted y equals the expected value.
5. Clear mid-MAC: assert clear_i at MAC cycle 2 -> next cycle h_ready_o=1, taps_loaded_o=0, busy_o=0; no y ever emitted.
6. Invalid channel: x_ch_i=3 -> the sample is accepted, err_o is high for exactly 1 cycle, no y is emitted, and the next valid ch0 sample produces its correct output.
